// File: rtl/sync_pkg.sv
// Shared definitions for the multi-channel SYNC marker generator.
package sync_pkg;

  localparam int unsigned CNT_W_DEF = 20;
  localparam int unsigned PW_W_DEF  = 8;
  localparam int unsigned MODE_W    = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_WIN   = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_TOG   = 2'b11
  } mode_e;

endpackage

// File: rtl/sync_marker_ch.sv
// One marker channel: window/pulse/toggle state, pulse counter, output polarity.
module sync_marker_ch
  import sync_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PW_W  = PW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] start_val,
  input  logic [CNT_W-1:0] end_val,
  input  mode_e            mode,
  input  logic             pol,
  input  logic [PW_W-1:0]  pw,
  output logic             sync_out
);

  logic            state_q, state_d;
  logic [PW_W-1:0] pcnt_q, pcnt_d;
  logic            out_q, out_d;
  logic            state_base;
  logic [PW_W-1:0] pcnt_base;
  logic            st, en;

  // Next channel state from the effective config; clr drops old-mode state first.
  always_comb begin
    state_base = clr ? 1'b0 : state_q;
    pcnt_base  = clr ? '0 : pcnt_q;
    st         = (cnt == start_val);
    en         = (cnt == end_val);
    state_d    = 1'b0;
    pcnt_d     = '0;
    if (valid) begin
      case (mode)
        MODE_WIN: begin
          if (en)      state_d = 1'b0;
          else if (st) state_d = 1'b1;
          else         state_d = state_base;
        end
        MODE_PULSE: begin
          if (st) begin
            pcnt_d  = (pw == '0) ? PW_W'(1) : pw;
            state_d = 1'b1;
          end else if (pcnt_base != '0) begin
            pcnt_d  = pcnt_base - PW_W'(1);
            state_d = (pcnt_base != PW_W'(1));
          end
        end
        MODE_TOG: state_d = st ? ~state_base : state_base;
        default:  state_d = 1'b0;
      endcase
    end
    out_d = state_d ^ pol;
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 1'b0;
      pcnt_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
    end
  end

  assign sync_out = out_q;

endmodule

// File: rtl/sync_marker_gen.sv
// Multi-channel SYNC marker generator with period-aligned double-buffered config.
module sync_marker_gen
  import sync_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PW_W  = PW_W_DEF
) (
  input  logic                  CLK200,
  input  logic                  RST,
  input  logic                  SYNC_VALID,
  input  logic [CNT_W-1:0]      SYNC_CNT_IN,
  input  logic [NCH*CNT_W-1:0]  START_IN,
  input  logic [NCH*CNT_W-1:0]  END_IN,
  input  logic [MODE_W*NCH-1:0] MODE_IN,
  input  logic [NCH-1:0]        POL_IN,
  input  logic [NCH*PW_W-1:0]   PW_IN,
  input  logic                  CFG_LOAD,
  output logic                  CFG_PENDING,
  output logic [NCH-1:0]        SYNC_OUT
);

  logic [NCH*CNT_W-1:0]  sh_start_q, sh_start_d, act_start_q, act_start_d;
  logic [NCH*CNT_W-1:0]  sh_end_q, sh_end_d, act_end_q, act_end_d;
  logic [MODE_W*NCH-1:0] sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [NCH-1:0]        sh_pol_q, sh_pol_d, act_pol_q, act_pol_d;
  logic [NCH*PW_W-1:0]   sh_pw_q, sh_pw_d, act_pw_q, act_pw_d;
  logic                  pend_q, pend_d;
  logic                  swap;
  logic [NCH-1:0]        mode_clr;

  // Shadow capture and swap; the next active set doubles as this cycle's effective config.
  always_comb begin
    swap        = pend_q && (!SYNC_VALID || (SYNC_CNT_IN == '0));
    sh_start_d  = CFG_LOAD ? START_IN : sh_start_q;
    sh_end_d    = CFG_LOAD ? END_IN   : sh_end_q;
    sh_mode_d   = CFG_LOAD ? MODE_IN  : sh_mode_q;
    sh_pol_d    = CFG_LOAD ? POL_IN   : sh_pol_q;
    sh_pw_d     = CFG_LOAD ? PW_IN    : sh_pw_q;
    act_start_d = swap ? sh_start_q : act_start_q;
    act_end_d   = swap ? sh_end_q   : act_end_q;
    act_mode_d  = swap ? sh_mode_q  : act_mode_q;
    act_pol_d   = swap ? sh_pol_q   : act_pol_q;
    act_pw_d    = swap ? sh_pw_q    : act_pw_q;
    pend_d      = CFG_LOAD ? 1'b1 : (swap ? 1'b0 : pend_q);
    for (int unsigned i = 0; i < NCH; i++) begin
      mode_clr[i] = swap && (sh_mode_q[MODE_W*i +: MODE_W] != act_mode_q[MODE_W*i +: MODE_W]);
    end
  end

  // Config registers.
  always_ff @(posedge CLK200) begin
    if (RST) begin
      sh_start_q  <= '0;
      sh_end_q    <= '0;
      sh_mode_q   <= '0;
      sh_pol_q    <= '0;
      sh_pw_q     <= '0;
      act_start_q <= '0;
      act_end_q   <= '0;
      act_mode_q  <= '0;
      act_pol_q   <= '0;
      act_pw_q    <= '0;
      pend_q      <= 1'b0;
    end else begin
      sh_start_q  <= sh_start_d;
      sh_end_q    <= sh_end_d;
      sh_mode_q   <= sh_mode_d;
      sh_pol_q    <= sh_pol_d;
      sh_pw_q     <= sh_pw_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_mode_q  <= act_mode_d;
      act_pol_q   <= act_pol_d;
      act_pw_q    <= act_pw_d;
      pend_q      <= pend_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sync_marker_ch #(
      .CNT_W (CNT_W),
      .PW_W  (PW_W)
    ) u_ch (
      .clk       (CLK200),
      .rst       (RST),
      .valid     (SYNC_VALID),
      .clr       (mode_clr[g]),
      .cnt       (SYNC_CNT_IN),
      .start_val (act_start_d[g*CNT_W +: CNT_W]),
      .end_val   (act_end_d[g*CNT_W +: CNT_W]),
      .mode      (mode_e'(act_mode_d[MODE_W*g +: MODE_W])),
      .pol       (act_pol_d[g]),
      .pw        (act_pw_d[g*PW_W +: PW_W]),
      .sync_out  (SYNC_OUT[g])
    );
  end

  assign CFG_PENDING = pend_q;

endmodule
